multiplicador_seq_param: RTL and testbench

Parametrised sequential shift-add multiplier, successor to the fixed 16×16 unsigned `multiplicador`. It adds a WIDTH parameter, a per-operation signed/unsigned mode and a Pronto/Ocupado handshake. It sits beside the ALU in the MIPS datapath as the multi-cycle unit behind MULT/MULTU, started by the control FSM and polled via Ocupado/Pronto.

---
 rtl/multiplicador_seq_param.sv | 119 +++++++++++
 tb/tb_multiplicador_seq_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq_param.sv
// Sequential shift-add multiplier with selectable signed/unsigned operands.
// One iteration per clock over WIDTH cycles, then a one-cycle result/Pronto stage.
//
// state | meaning
// IDLE  | waiting for St; operands and mode captured on start
// CALC  | one shift-add iteration per cycle, WIDTH iterations
// FIM   | apply sign to the magnitude, load Produto, pulse Pronto

module multiplicador_seq_param #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               St,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    output logic [2*WIDTH-1:0] Produto,
    output logic               Pronto,
    output logic               Ocupado
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic               last_iter;

    // The most-negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
    always_comb begin
        mag_a = Multiplicando;
        mag_b = Multiplicador;
        if (Signed && Multiplicando[WIDTH-1]) begin
            mag_a = -Multiplicando;
        end
        if (Signed && Multiplicador[WIDTH-1]) begin
            mag_b = -Multiplicador;
        end
    end

    // Upper half accumulates partial products; lower half holds the multiplier being shifted out.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (St) state_next = CALC;
            CALC: if (last_iter) state_next = FIM;
            FIM:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            Produto <= '0;
            Pronto  <= 1'b0;
        end else begin
            Pronto <= 1'b0;
            case (state)
                IDLE: begin
                    if (St) begin
                        mcand <= mag_a;
                        acc   <= {{WIDTH{1'b0}}, mag_b};
                        cnt   <= '0;
                        neg   <= Signed & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
                    end
                end
                CALC: begin
                    acc <= {sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                FIM: begin
                    Produto <= neg ? -acc : acc;
                    Pronto  <= 1'b1;
                end
                default: begin
                    Pronto <= 1'b0;
                end
            endcase
        end
    end

    assign Ocupado = (state != IDLE);

endmodule

// File: tb/tb_multiplicador_seq_param.sv
// Bench for multiplicador_seq_param: WIDTH=16 and WIDTH=8 instances checked against
// an integer-arithmetic reference with directed and random operands.

module tb_multiplicador_seq_param;

    logic        clk;
    logic        reset;

    logic        st16, sgn16;
    logic [15:0] a16, b16;
    logic [31:0] produto16;
    logic        pronto16, ocupado16;

    logic        st8, sgn8;
    logic [7:0]  a8, b8;
    logic [15:0] produto8;
    logic        pronto8, ocupado8;

    int total = 0;
    int bad   = 0;

    multiplicador_seq_param #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(reset), .St(st16), .Signed(sgn16),
        .Multiplicando(a16), .Multiplicador(b16),
        .Produto(produto16), .Pronto(pronto16), .Ocupado(ocupado16)
    );

    multiplicador_seq_param #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(reset), .St(st8), .Signed(sgn8),
        .Multiplicando(a8), .Multiplicador(b8),
        .Produto(produto8), .Pronto(pronto8), .Ocupado(ocupado8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: interpret operands as integers of the chosen signedness, multiply, keep 2*w bits.
    function automatic logic [31:0] model(input int w, input logic sgn,
                                          input logic [15:0] a, input logic [15:0] b);
        longint ma, sa, sb, p;
        ma = (longint'(1) << w) - 1;
        sa = longint'(a) & ma;
        sb = longint'(b) & ma;
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    function automatic logic [31:0] prod(input int w);
        return (w == 16) ? produto16 : {16'b0, produto8};
    endfunction

    function automatic logic busy(input int w);
        return (w == 16) ? ocupado16 : ocupado8;
    endfunction

    function automatic logic done(input int w);
        return (w == 16) ? pronto16 : pronto8;
    endfunction

    task automatic run_op(input int w, input logic sgn, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] expv, input string tag);
        int n;
        if (w == 16) begin
            sgn16 = sgn; a16 = a; b16 = b; st16 = 1'b1;
        end else begin
            sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1;
        end
        tick;
        st16 = 1'b0;
        st8  = 1'b0;
        check({tag, "_busy"}, 32'(busy(w)), 32'd1);
        n = 0;
        while (done(w) !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(w + 1));
        check({tag, "_prod"}, prod(w), expv);
        check({tag, "_idle"}, 32'(busy(w)), 32'd0);
        tick;
        check({tag, "_pulse_end"}, 32'(done(w)), 32'd0);
        check({tag, "_hold"}, prod(w), expv);
    endtask

    initial begin
        logic [15:0] ra, rb, a0, b0, a1, b1;
        logic        rs, s0, s1, early;
        logic [31:0] e0, e1;

        reset = 1'b0;
        st16 = 1'b1; sgn16 = 1'b0; a16 = 16'd5; b16 = 16'd6;
        st8  = 1'b1; sgn8  = 1'b0; a8  = 8'd3;  b8  = 8'd4;

        // Reset held low with St asserted: nothing may start.
        repeat (3) tick;
        check("rst_prod16",   produto16,          32'd0);
        check("rst_pronto16", 32'(pronto16),      32'd0);
        check("rst_busy16",   32'(ocupado16),     32'd0);
        check("rst_prod8",    {16'b0, produto8},  32'd0);
        check("rst_pronto8",  32'(pronto8),       32'd0);
        check("rst_busy8",    32'(ocupado8),      32'd0);

        st8 = 1'b0;
        reset = 1'b1;
        run_op(16, 1'b0, 16'd5, 16'd6, 32'd30, "rst_release");

        run_op(16, 1'b0, 16'd2000, 16'd2000, 32'h003D0900, "u2000x2000");
        run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "uffffxffff");
        run_op(16, 1'b1, 16'hFFFD, 16'd7,    32'hFFFFFFEB, "s_m3x7");
        run_op(16, 1'b1, 16'h8000, 16'h8000, 32'h40000000, "s_minxmin");
        run_op(16, 1'b1, 16'd0,    16'hFFFB, 32'h00000000, "s_0xm5");
        run_op(16, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "s_minxmax");

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(16, rs, ra, rb, model(16, rs, ra, rb), "rnd16");
        end

        // St held high, operands scrambled every cycle after capture.
        a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'($urandom_range(0, 1));
        e0 = model(16, s0, a0, b0);
        sgn16 = s0; a16 = a0; b16 = b0; st16 = 1'b1;
        tick;
        check("b2b_busy0", 32'(ocupado16), 32'd1);
        early = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom_range(0, 1));
            if (pronto16) early = 1'b1;
            tick;
        end
        check("b2b_early0", 32'(early), 32'd0);
        check("b2b_pronto17", 32'(pronto16), 32'd1);
        check("b2b_prod0", produto16, e0);

        a1 = 16'($urandom) | 16'd1; b1 = 16'($urandom) | 16'd1; s1 = 1'($urandom_range(0, 1));
        e1 = model(16, s1, a1, b1);
        sgn16 = s1; a16 = a1; b16 = b1;
        tick;
        check("b2b_busy18", 32'(ocupado16), 32'd1);
        check("b2b_pronto18", 32'(pronto16), 32'd0);
        check("b2b_hold18", produto16, e0);
        early = 1'b0;
        for (int i = 19; i <= 35; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom_range(0, 1));
            if (pronto16) early = 1'b1;
            tick;
        end
        check("b2b_early1", 32'(early), 32'd0);
        check("b2b_pronto35", 32'(pronto16), 32'd1);
        check("b2b_prod1", produto16, e1);
        st16 = 1'b0;
        tick;
        check("b2b_idle", 32'(ocupado16), 32'd0);
        check("b2b_pulse_end", 32'(pronto16), 32'd0);

        // Reset during CALC iteration 5 aborts without a completion pulse.
        sgn16 = 1'b0; a16 = 16'd1234; b16 = 16'd4321; st16 = 1'b1;
        tick;
        st16 = 1'b0;
        repeat (4) tick;
        reset = 1'b0;
        tick;
        check("abort_prod", produto16, 32'd0);
        check("abort_pronto", 32'(pronto16), 32'd0);
        check("abort_busy", 32'(ocupado16), 32'd0);
        reset = 1'b1;
        early = 1'b0;
        repeat (25) begin
            if (pronto16) early = 1'b1;
            tick;
        end
        check("abort_no_pulse", 32'(early), 32'd0);
        run_op(16, 1'b0, 16'd12, 16'd12, 32'd144, "after_abort");

        run_op(8, 1'b0, 16'd200,  16'd200,  32'h00009C40, "w8_u200x200");
        run_op(8, 1'b1, 16'h0080, 16'h007F, 32'h0000C080, "w8_s_minxmax");
        run_op(8, 1'b1, 16'h0080, 16'h0080, 32'h00004000, "w8_s_minxmin");
        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            run_op(8, rs, ra, rb, model(8, rs, ra, rb), "rnd8");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
